// File: rtl/seq_div16by8.sv
// Sequential signed 2N/N divider: restoring division on magnitudes, one quotient
// bit per clock, start/done handshake, with overflow and divide-by-zero flags.
module seq_div16by8 #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             ovf,
    output logic             dz
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] QPOS_MAX = W'((1 << (N - 1)) - 1);
    localparam logic [W-1:0] QNEG_MAG = W'(1 << (N - 1));

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state;
    logic          sign_q;
    logic          sign_r;
    logic          dz_pend;
    logic [N:0]    prem;
    logic [W-1:0]  qreg;
    logic [N-1:0]  dmag;
    logic [CW-1:0] count;

    logic [N:0]    shifted;
    logic [N+1:0]  trial;
    logic          q_ovf;

    // qreg starts as |dividend| and fills with quotient bits from the right.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shifted = {prem[N-1:0], qreg[W-1]};
        trial   = {1'b0, shifted} - {2'b00, dmag};
        q_ovf   = sign_q ? (qreg > QNEG_MAG) : (qreg > QPOS_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_pend   <= 1'b0;
            prem      <= '0;
            qreg      <= '0;
            dmag      <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q  <= dividend[W-1] ^ divisor[N-1];
                        sign_r  <= dividend[W-1];
                        qreg    <= dividend[W-1] ? -dividend : dividend;
                        dmag    <= divisor[N-1] ? -divisor : divisor;
                        prem    <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        ovf     <= 1'b0;
                        dz      <= 1'b0;
                        dz_pend <= (divisor == '0);
                        state   <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    // A set top bit of trial is a borrow: restore the shifted remainder.
                    prem  <= trial[N+1] ? shifted : trial[N:0];
                    qreg  <= {qreg[W-2:0], ~trial[N+1]};
                    count <= count + CW'(1);
                    if (count == CW'(W - 1))
                        state <= FIX;
                end
                FIX: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (dz_pend) begin
                        quotient  <= '0;
                        remainder <= '0;
                        ovf       <= 1'b0;
                        dz        <= 1'b1;
                    end else if (q_ovf) begin
                        quotient  <= '0;
                        remainder <= '0;
                        ovf       <= 1'b1;
                        dz        <= 1'b0;
                    end else begin
                        quotient  <= sign_q ? -qreg[N-1:0] : qreg[N-1:0];
                        remainder <= sign_r ? -prem[N-1:0] : prem[N-1:0];
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
